// File: rtl/mu0_control.sv
// MU0 control unit: three-state fetch/execute sequencer driving the datapath
// selects, register load enables and the memory handshake.
module mu0_control #(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] F,
   input  logic       N,
   input  logic       Z,
   input  logic       Mem_rdy,
   output logic       X_sel,
   output logic       Y_sel,
   output logic       Addr_sel,
   output logic [1:0] ALU_fs,
   output logic       PC_En,
   output logic       IR_En,
   output logic       Acc_En,
   output logic       MEMrq,
   output logic       RnW,
   output logic       Halted
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_EXECUTE = 2'd1,
      S_HALTED  = 2'd2
   } state_e;

   localparam logic [1:0] FS_Y    = 2'b00;
   localparam logic [1:0] FS_ADD  = 2'b01;
   localparam logic [1:0] FS_INC  = 2'b10;
   localparam logic [1:0] FS_SUB  = 2'b11;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;

   typedef struct packed {
      logic       x_sel;
      logic       y_sel;
      logic       addr_sel;
      logic [1:0] alu_fs;
      logic       pc_en;
      logic       ir_en;
      logic       acc_en;
      logic       memrq;
      logic       rnw;
      logic       halted;
   } ctl_t;

   state_e state_q, state_d;
   ctl_t   ctl;
   logic   br_taken;

   assign br_taken = (F == OP_JMP) || ((F == OP_JGE) && !N) || ((F == OP_JNE) && !Z);

   always_comb begin
      ctl     = '0;
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            // PC increments through the ALU while the instruction is read
            ctl.addr_sel = 1'b0;
            ctl.memrq    = 1'b1;
            ctl.rnw      = 1'b1;
            ctl.x_sel    = 1'b1;
            ctl.alu_fs   = FS_INC;
            ctl.ir_en    = Mem_rdy;
            ctl.pc_en    = Mem_rdy;
            if (Mem_rdy) state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            case (F)
               OP_LDA, OP_ADD, OP_SUB: begin
                  ctl.addr_sel = 1'b1;
                  ctl.memrq    = 1'b1;
                  ctl.rnw      = 1'b1;
                  ctl.y_sel    = 1'b0;
                  ctl.x_sel    = 1'b0;
                  ctl.alu_fs   = (F == OP_ADD) ? FS_ADD :
                                 (F == OP_SUB) ? FS_SUB : FS_Y;
                  ctl.acc_en   = Mem_rdy;
                  if (Mem_rdy) state_d = S_FETCH;
               end
               OP_STA: begin
                  ctl.addr_sel = 1'b1;
                  ctl.memrq    = 1'b1;
                  ctl.rnw      = 1'b0;
                  ctl.x_sel    = 1'b0;
                  if (Mem_rdy) state_d = S_FETCH;
               end
               OP_JMP, OP_JGE, OP_JNE: begin
                  // untaken branch leaves every output low for one cycle
                  if (br_taken) begin
                     ctl.y_sel  = 1'b1;
                     ctl.alu_fs = FS_Y;
                     ctl.pc_en  = 1'b1;
                  end
                  state_d = S_FETCH;
               end
               OP_STP: state_d = S_HALTED;
               default: state_d = HALT_ON_ILLEGAL ? S_HALTED : S_FETCH;
            endcase
         end
         S_HALTED: begin
            ctl.halted = 1'b1;
            state_d    = S_HALTED;
         end
         default: state_d = S_FETCH;
      endcase
      if (Reset) begin
         ctl     = '0;
         ctl.rnw = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign X_sel    = ctl.x_sel;
   assign Y_sel    = ctl.y_sel;
   assign Addr_sel = ctl.addr_sel;
   assign ALU_fs   = ctl.alu_fs;
   assign PC_En    = ctl.pc_en;
   assign IR_En    = ctl.ir_en;
   assign Acc_En   = ctl.acc_en;
   assign MEMrq    = ctl.memrq;
   assign RnW      = ctl.rnw;
   assign Halted   = ctl.halted;

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control: directed vector table, reset/illegal corner sequences and
// randomized cycles against an instruction-level reference model, for both HALT_ON_ILLEGAL settings.
module tb_mu0_control;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] F = 4'h0;
   logic       N = 1'b0, Z = 1'b0, Mem_rdy = 1'b1;
   wire  [10:0] o0, o1;   // {X,Y,Addr,ALU_fs[1:0],PC_En,IR_En,Acc_En,MEMrq,RnW,Halted}

   int checks = 0, failures = 0;

   always #5 Clk = ~Clk;

   mu0_control #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
      .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_rdy(Mem_rdy),
      .X_sel(o0[10]), .Y_sel(o0[9]), .Addr_sel(o0[8]), .ALU_fs(o0[7:6]),
      .PC_En(o0[5]), .IR_En(o0[4]), .Acc_En(o0[3]), .MEMrq(o0[2]), .RnW(o0[1]), .Halted(o0[0]));

   mu0_control #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
      .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_rdy(Mem_rdy),
      .X_sel(o1[10]), .Y_sel(o1[9]), .Addr_sel(o1[8]), .ALU_fs(o1[7:6]),
      .PC_En(o1[5]), .IR_En(o1[4]), .Acc_En(o1[3]), .MEMrq(o1[2]), .RnW(o1[1]), .Halted(o1[0]));

   localparam logic [10:0] V_RST   = 11'b000_00_000_010;
   localparam logic [10:0] V_FR    = 11'b100_10_110_110;
   localparam logic [10:0] V_FS    = 11'b100_10_000_110;
   localparam logic [10:0] V_LDA   = 11'b001_00_001_110;
   localparam logic [10:0] V_ADD   = 11'b001_01_001_110;
   localparam logic [10:0] V_ADDS  = 11'b001_01_000_110;
   localparam logic [10:0] V_STA   = 11'b001_00_000_100;
   localparam logic [10:0] V_JMP   = 11'b010_00_100_000;
   localparam logic [10:0] V_NONE  = 11'b000_00_000_000;
   localparam logic [10:0] V_HALT  = 11'b000_00_000_001;

   typedef enum int {PH_FETCH, PH_EXEC, PH_HALT} phase_e;
   phase_e ph0 = PH_FETCH, ph1 = PH_FETCH;

   // Reference: what an instruction phase must drive, from the opcode's meaning.
   function automatic logic [10:0] model_out(phase_e ph, logic r, logic [3:0] f, logic n, logic z, logic rdy);
      logic [1:0] fs;
      if (r) return V_RST;
      if (ph == PH_HALT) return V_HALT;
      if (ph == PH_FETCH) return rdy ? V_FR : V_FS;
      if (f < 4) begin
         fs = (f == 2) ? 2'b01 : (f == 3) ? 2'b11 : 2'b00;
         if (f == 1) return {3'b001, 2'b00, 3'b000, 2'b10, 1'b0};
         return {3'b001, fs, 2'b00, rdy, 2'b11, 1'b0};
      end
      if (f == 4 || (f == 5 && !n) || (f == 6 && !z)) return V_JMP;
      return V_NONE;
   endfunction

   function automatic phase_e model_next(phase_e ph, logic r, logic [3:0] f, logic rdy, bit hoi);
      if (r) return PH_FETCH;
      if (ph == PH_HALT) return PH_HALT;
      if (ph == PH_FETCH) return rdy ? PH_EXEC : PH_FETCH;
      if (f < 4) return rdy ? PH_FETCH : PH_EXEC;
      if (f == 7 || (f >= 8 && hoi)) return PH_HALT;
      return PH_FETCH;
   endfunction

   task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %b want %b", nm, got, want);
      end
   endtask

   task automatic chk_excl(input string nm, input logic [10:0] o, input phase_e ph);
      int n_en;
      n_en = int'(o[5]) + int'(o[4]) + int'(o[3]);
      checks++;
      if (!(n_en <= 1 || (o[5] && o[4] && !o[3] && ph == PH_FETCH))) begin
         failures++;
         $display("FAIL %s excl: got PC/IR/Acc=%b want at most one", nm, o[5:3]);
      end
   endtask

   // One clock: drive at posedge+1, check at negedge, advance the model at the posedge.
   task automatic step(input logic r, input logic [3:0] f, input logic n, input logic z,
                       input logic rdy, input bit use_exp, input logic [10:0] e0,
                       input logic [10:0] e1, input string nm);
      Reset = r; F = f; N = n; Z = z; Mem_rdy = rdy;
      @(negedge Clk);
      chk({nm, " m0"}, o0, model_out(ph0, r, f, n, z, rdy));
      chk({nm, " m1"}, o1, model_out(ph1, r, f, n, z, rdy));
      if (use_exp) begin
         chk({nm, " v0"}, o0, e0);
         chk({nm, " v1"}, o1, e1);
      end
      chk_excl({nm, " d0"}, o0, ph0);
      chk_excl({nm, " d1"}, o1, ph1);
      @(posedge Clk);
      ph0 = model_next(ph0, r, f, rdy, 1'b0);
      ph1 = model_next(ph1, r, f, rdy, 1'b1);
      #1;
   endtask

   typedef struct {
      logic       r;
      logic [3:0] f;
      logic       n, z, rdy;
      logic [10:0] exp;
   } vec_t;

   initial begin
      vec_t tbl[28];
      tbl = '{
         '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, V_RST},
         '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, V_FR},
         '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, V_LDA},
         '{1'b0, 4'h2, 1'b0, 1'b0, 1'b1, V_FR},
         '{1'b0, 4'h2, 1'b0, 1'b0, 1'b1, V_ADD},
         '{1'b0, 4'h1, 1'b0, 1'b0, 1'b1, V_FR},
         '{1'b0, 4'h1, 1'b0, 1'b0, 1'b1, V_STA},
         '{1'b0, 4'h7, 1'b0, 1'b0, 1'b1, V_FR},
         '{1'b0, 4'h7, 1'b0, 1'b0, 1'b1, V_NONE},
         '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, V_HALT},
         '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, V_RST},
         '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, V_FS},
         '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, V_FS},
         '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, V_FS},
         '{1'b0, 4'h5, 1'b1, 1'b0, 1'b1, V_FR},
         '{1'b0, 4'h5, 1'b1, 1'b0, 1'b1, V_NONE},
         '{1'b0, 4'h5, 1'b0, 1'b0, 1'b1, V_FR},
         '{1'b0, 4'h5, 1'b0, 1'b0, 1'b1, V_JMP},
         '{1'b0, 4'h6, 1'b0, 1'b1, 1'b1, V_FR},
         '{1'b0, 4'h6, 1'b0, 1'b1, 1'b1, V_NONE},
         '{1'b0, 4'h6, 1'b0, 1'b0, 1'b1, V_FR},
         '{1'b0, 4'h6, 1'b0, 1'b0, 1'b1, V_JMP},
         '{1'b0, 4'h4, 1'b1, 1'b1, 1'b0, V_FR},
         '{1'b0, 4'h4, 1'b1, 1'b1, 1'b0, V_JMP},
         '{1'b0, 4'h2, 1'b0, 1'b0, 1'b1, V_FR},
         '{1'b0, 4'h2, 1'b0, 1'b0, 1'b0, V_ADDS},
         '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, V_RST},
         '{1'b0, 4'h2, 1'b0, 1'b0, 1'b0, V_FS}
      };
      // entry 22 stalls memory in FETCH: make it ready so the JMP row follows
      tbl[22].rdy = 1'b1;

      @(posedge Clk); #1;
      foreach (tbl[i])
         step(tbl[i].r, tbl[i].f, tbl[i].n, tbl[i].z, tbl[i].rdy, 1'b1,
              tbl[i].exp, tbl[i].exp, $sformatf("vec%0d", i));

      // illegal opcode: no-op for dut0, halt for dut1
      step(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, V_RST,  V_RST,  "ill rst");
      step(1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, V_FR,   V_FR,   "ill fetch");
      step(1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, V_NONE, V_NONE, "ill exec");
      step(1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, V_FS,   V_HALT, "ill next");
      step(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, V_FR,   V_HALT, "ill absorb");

      // long stalled memory execute, then reset out of it
      step(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, V_RST, V_RST, "stall rst");
      step(1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, V_RST, V_RST, "stall f");
      for (int k = 0; k < 4; k++)
         step(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1,
              11'b001_11_000_110, 11'b001_11_000_110, "sub stall");
      step(1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1,
           11'b001_11_001_110, 11'b001_11_001_110, "sub done");
      step(1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, V_FR, V_FR, "after sub");

      // randomized cycles against the reference model
      for (int k = 0; k < 600; k++)
         step(($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)),
              1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7),
              1'b0, V_RST, V_RST, "rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
